dmem_mmio_responder: RTL
========================

Name: dmem_mmio_responder

Overview:
- Memory-side responder for the single-cycle RV32I core's data port.
- Accepts the core's address, write data and write strobe, and returns read data in the same cycle.
- Decodes two regions: a word-organised data RAM and a small MMIO block. The MMIO block holds a GPIO output register, a free-running cycle counter, a compare timer with an interrupt, and a sticky unmapped-write error capture.

Parameters:
- RAM_WORDS, 256, RAM depth in 32-bit words (power of 2). RAM occupies byte addresses 0 to RAM_WORDS*4-1.
- MMIO_BASE, 32'hFFFF_0000, base byte address of the 64-byte MMIO window.
- GPIO_W, 8, width of the GPIO output register.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- DataAdr  input  32  byte address from the core's ALU result
- WriteData  input  32  full word to store; sub-word merging is already done by the core
- MemWrite  input  1  write strobe, sampled on the rising edge of clk
- ReadData  output  32  combinational read data for DataAdr
- gpio_out  output  GPIO_W  GPIO register contents
- timer_irq  output  1  level interrupt, equal to expired AND en
- bus_err  output  1  sticky unmapped-write flag

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Word index: DataAdr[1:0] is ignored for decode and storage. Word index is DataAdr[log2(RAM_WORDS)+1:2].
- Reads:
  - Purely combinational from DataAdr; zero cycles of latency, as the single-cycle core requires.
  - A same-cycle write does not affect ReadData. ReadData shows the pre-edge value.
  - Unmapped addresses and reserved MMIO offsets read 0.
- Writes: occur on the rising edge of clk when MemWrite=1. Writes are always full-word.
- RAM: contents are not reset. Simulation initialises RAM to 0.
- MMIO offsets from MMIO_BASE (any other offset inside the 64-byte window is reserved: reads 0, writes are ignored and do not set bus_err):
  - 0x00 GPIO: RW, low GPIO_W bits; upper bits read 0.
  - 0x04 CYCLE: RW, 32-bit.
    - Increments by 1 every cycle and wraps from FFFF_FFFF to 0.
    - A write loads WriteData; counting resumes from the loaded value on the following edge.
  - 0x08 CMP: RW, 32-bit compare value.
  - 0x0C CTRL: RW, bit0 = en; other bits read 0.
  - 0x10 STATUS: bit0 = expired, W1C. Writing 1 clears it; writing 0 has no effect.
  - 0x14 ERRADDR: RO, address of the first unmapped write since the last clear. Writes to it are ignored.
  - 0x18 ERRCLR: write any value to clear bus_err and ERRADDR. Reads 0.
- Timer:
  - On each edge where en=1 and the current CYCLE == CMP, expired is set to 1.
  - If a STATUS W1C and a new match occur on the same edge, the set wins.
  - Writing en=0 leaves expired unchanged but masks timer_irq.
- Unmapped write: MemWrite=1 to an address in neither RAM nor the MMIO window.
  - No state changes except the error capture below.
  - If bus_err=0, bus_err is set to 1 and ERRADDR captures the full 32-bit DataAdr.
  - If bus_err is already 1, ERRADDR is held, so the first error is kept.
  - If an ERRCLR write and an unmapped write could occur on the same edge: they cannot, because each cycle carries one address.
- Reset values: gpio_out=0, CYCLE=0, CMP=FFFF_FFFF, en=0, expired=0, timer_irq=0, bus_err=0, ERRADDR=0.
  - ReadData follows the current address and register state.
- Reset asserted mid-operation: all registers clear immediately (asynchronously). RAM contents are retained.

Test Plan:
- RAM write/read: write 0xDEADBEEF to 0x0000_0010; on the next cycle read 0x0000_0013 -> ReadData=0xDEADBEEF. A read of 0x10 during the write cycle -> old value 0.
- GPIO: write 0x1A5 to MMIO_BASE+0x00 -> gpio_out=0xA5; reading it back gives 0x0000_00A5. Assert reset -> gpio_out=0 immediately, with no clock edge.
- Cycle counter wrap: write FFFF_FFFE to CYCLE -> reads FFFF_FFFE, then FFFF_FFFF, then 0, on successive cycles.
- Timer:
  - Write CMP=20, CTRL=1 and CYCLE=10 -> timer_irq rises on the edge after CYCLE reads 20.
  - W1C STATUS -> irq=0.
  - Issue W1C on the exact edge where CYCLE==CMP -> expired stays 1.
- Unmapped writes:
  - Write to 0x8000_0004 -> bus_err=1, ERRADDR=0x8000_0004, RAM and MMIO unchanged.
  - A second write to 0x8000_0008 -> ERRADDR unchanged.
  - ERRCLR write -> bus_err=0, ERRADDR=0.
- Reserved offset: write to MMIO_BASE+0x3C -> no state change, bus_err=0; reading it returns 0.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// Data-port responder for the single-cycle RV32I core: word RAM plus a small MMIO block
// (GPIO, cycle counter, compare timer, unmapped-write capture). Reads are combinational.
module dmem_mmio_responder #(
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  input  logic              MemWrite,
  output logic [31:0]       ReadData,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);
  localparam int unsigned AW = $clog2(RAM_WORDS);

  localparam logic [3:0] OFF_GPIO    = 4'd0;
  localparam logic [3:0] OFF_CYCLE   = 4'd1;
  localparam logic [3:0] OFF_CMP     = 4'd2;
  localparam logic [3:0] OFF_CTRL    = 4'd3;
  localparam logic [3:0] OFF_STATUS  = 4'd4;
  localparam logic [3:0] OFF_ERRADDR = 4'd5;
  localparam logic [3:0] OFF_ERRCLR  = 4'd6;

  logic [31:0]       mem_q [RAM_WORDS];
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              en_q, en_d;
  logic              expired_q, expired_d;
  logic              err_q, err_d;
  logic [31:0]       erraddr_q, erraddr_d;

  logic          ram_hit, mmio_hit, unmapped_we, match;
  logic [3:0]    off;
  logic [AW-1:0] widx;
  logic          unused_lo;

  // Byte lane bits never participate in decode.
  assign unused_lo = ^DataAdr[1:0];

  assign ram_hit     = (DataAdr[31:AW+2] == '0);
  assign mmio_hit    = !ram_hit && (DataAdr[31:6] == MMIO_BASE[31:6]);
  assign unmapped_we = MemWrite && !ram_hit && !mmio_hit;
  assign off         = DataAdr[5:2];
  assign widx        = DataAdr[AW+1:2];
  assign match       = en_q && (cycle_q == cmp_q);

  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) mem_q[widx] <= WriteData;
  end

  always_comb begin
    gpio_d    = gpio_q;
    cycle_d   = cycle_q + 32'd1;
    cmp_d     = cmp_q;
    en_d      = en_q;
    expired_d = expired_q;
    err_d     = err_q;
    erraddr_d = erraddr_q;
    if (MemWrite && mmio_hit) begin
      case (off)
        OFF_GPIO:   gpio_d    = WriteData[GPIO_W-1:0];
        OFF_CYCLE:  cycle_d   = WriteData;
        OFF_CMP:    cmp_d     = WriteData;
        OFF_CTRL:   en_d      = WriteData[0];
        OFF_STATUS: if (WriteData[0]) expired_d = 1'b0;
        OFF_ERRCLR: begin
          err_d     = 1'b0;
          erraddr_d = '0;
        end
        default: ;
      endcase
    end
    // A fresh match overrides a same-edge W1C.
    if (match) expired_d = 1'b1;
    if (unmapped_we && !err_q) begin
      err_d     = 1'b1;
      erraddr_d = DataAdr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q    <= '0;
      cycle_q   <= '0;
      cmp_q     <= 32'hFFFF_FFFF;
      en_q      <= 1'b0;
      expired_q <= 1'b0;
      err_q     <= 1'b0;
      erraddr_q <= '0;
    end else begin
      gpio_q    <= gpio_d;
      cycle_q   <= cycle_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      expired_q <= expired_d;
      err_q     <= err_d;
      erraddr_q <= erraddr_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (ram_hit) ReadData = mem_q[widx];
    else if (mmio_hit) begin
      case (off)
        OFF_GPIO:    ReadData = 32'(gpio_q);
        OFF_CYCLE:   ReadData = cycle_q;
        OFF_CMP:     ReadData = cmp_q;
        OFF_CTRL:    ReadData = {31'b0, en_q};
        OFF_STATUS:  ReadData = {31'b0, expired_q};
        OFF_ERRADDR: ReadData = erraddr_q;
        default: ;
      endcase
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = expired_q && en_q;
  assign bus_err   = err_q;
endmodule
